seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Time-multiplexed scanner that drives a multi-digit common-segment 7-segment display from a packed hex value. It sits directly upstream of the seg7 decoder and presents one 4-bit digit code at a time, together with a one-hot digit enable. Values are double-buffered, so a displayed frame never mixes old and new digits. It also supports leading-zero blanking and per-digit decimal points.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (legal range 2..8)
REFRESH_DIV, 2500, clk cycles each digit stays lit (must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
value_in  input  4*NUM_DIGITS  packed hex value; bits [3:0] are digit 0 (rightmost)
dp_in  input  NUM_DIGITS  decimal point per digit, captured with value_in
load  input  1  single-cycle strobe; captures value_in and dp_in
blank_en  input  1  leading-zero blanking enable (level, used live)
digit_out  output  4  hex code of the currently scanned digit, feeds the seg7 decoder
dp_out  output  1  decimal point of the currently scanned digit
an_out  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero when the slot is blanked
frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Registered state:
  - prescaler, width max(1,clog2(REFRESH_DIV))
  - idx, width max(1,clog2(NUM_DIGITS))
  - active_val / active_dp, the displayed value
  - pending_val / pending_dp and pending_flag, the shadow value
  - frame_tick, a registered output
- Reset (rst=1 at an edge): prescaler=0, idx=0, active_val=0, active_dp=0, pending_val=0, pending_dp=0, pending_flag=0, frame_tick=0.
  - Outputs after reset: an_out=one-hot bit 0, digit_out=0, dp_out=0.
  - Reset mid-frame or mid-pending aborts immediately; any pending value is discarded.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal count is prescaler==REFRESH_DIV-1. With REFRESH_DIV=1 every cycle is terminal.
- Scan:
  - On a terminal count, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - The wrap cycle is the frame boundary. On the following cycle frame_tick=1 for exactly one cycle.
- Load handling:
  - load outside a frame boundary: pending_val/pending_dp <= inputs, pending_flag <= 1. Repeated loads within a frame overwrite the shadow; the last one wins.
  - Frame boundary without load: if pending_flag=1, active <= pending and pending_flag <= 0. Otherwise active is held.
  - load on the frame-boundary cycle: active <= value_in/dp_in directly (bypass) and pending_flag <= 0. The new value is shown from digit 0 of the frame that starts on that edge.
- Outputs are combinational from registered idx, active_val, active_dp and the blank_en input (no extra latency):
  - digit_out = active_val[4*idx +: 4]
  - dp_out = active_dp[idx]
  - an_out = one-hot(idx), unless the slot is blanked.
- Blanking rule:
  - Slot idx>0 is blanked when blank_en=1 and every nibble from NUM_DIGITS-1 down to idx is zero, with dp_in ignored for this test.
  - Blanked slot: an_out=0, digit_out=0, dp_out=0.
  - Digit 0 is never blanked.
- No handshake backpressure: load is always accepted.

Test Plan:
(All cases use NUM_DIGITS=4, REFRESH_DIV=4.)
1. Reset, then load 0x1234 with dp_in=0. After the first frame_tick, over 16 cycles:
   - digit_out = 4,3,2,1
   - an_out = 0001,0010,0100,1000
   - each held 4 cycles; frame_tick pulses every 16 cycles.
2. Tear-free update: while 0x1234 is displayed, pulse load=1 with 0xABCD when idx=1. The rest of that frame still shows 2,1. The next frame shows D,C,B,A.
3. Leading-zero blanking:
   - active 0x0050, blank_en=1 → an_out = 0001 (digit 0), 0010 (digit 5), 0000, 0000.
   - same value with blank_en=0 → all four slots enabled.
   - active 0x0000, blank_en=1 → only digit 0 lit, showing 0.
4. Bypass: load 0x9876 on the frame-boundary cycle (idx=3, prescaler=3). The next cycle shows idx=0, digit_out=6, frame_tick=1, and pending_flag=0.
5. Decimal point and last-wins: load 0x1111 with dp_in=0001, then 0x2222 with dp_in=0100 in the same frame. The next frame shows 2 on every digit, with dp_out=1 only on digit 2.
6. Mid-operation reset: load 0x5555, then assert rst for 1 cycle before the frame boundary. The result is idx=0, an_out=0001, digit_out=0, and 0x5555 never appears in any later frame.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed scanner for a NUM_DIGITS common-segment
// 7-segment display. It shows one nibble at a time with a one-hot anode enable.
// Values are double-buffered, so a frame never mixes old and new digits.
// It also does leading-zero blanking and per-digit decimal points.

// Per-digit leading-zero chain stage: the slot is "zero from here up" when
// its own nibble is zero and every more-significant nibble is zero too.
module seg7_scan_slot (
    input  logic [3:0] nibble,
    input  logic       zero_above,
    output logic       zero_here
);
    assign zero_here = zero_above && (nibble == 4'd0);
endmodule

module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 2500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_en,
    output logic [3:0]              digit_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active_val, pending_val;
    logic [NUM_DIGITS-1:0]   active_dp, pending_dp;
    logic                    pending_flag;

    logic terminal, wrap;
    assign terminal = (prescaler == PW'(REFRESH_DIV - 1));
    assign wrap     = terminal && (idx == IW'(NUM_DIGITS - 1));

    // Prescaler, scan index, frame tick and the double-buffered value.
    // A load on the wrap cycle bypasses the shadow so that it is shown from
    // digit 0 of the frame that starts on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            idx          <= '0;
            active_val   <= '0;
            active_dp    <= '0;
            pending_val  <= '0;
            pending_dp   <= '0;
            pending_flag <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            prescaler  <= terminal ? '0 : prescaler + PW'(1);
            frame_tick <= wrap;
            if (terminal)
                idx <= wrap ? '0 : idx + IW'(1);
            if (wrap) begin
                if (load) begin
                    active_val <= value_in;
                    active_dp  <= dp_in;
                end else if (pending_flag) begin
                    active_val <= pending_val;
                    active_dp  <= pending_dp;
                end
                pending_flag <= 1'b0;
            end else if (load) begin
                pending_val  <= value_in;
                pending_dp   <= dp_in;
                pending_flag <= 1'b1;
            end
        end
    end

    // zero_from[i]: nibbles NUM_DIGITS-1 down to i are all zero
    logic [NUM_DIGITS:0] zero_from;
    assign zero_from[NUM_DIGITS] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
        seg7_scan_slot u_slot (
            .nibble     (active_val[4*i +: 4]),
            .zero_above (zero_from[i+1]),
            .zero_here  (zero_from[i])
        );
    end

    logic blanked;
    assign blanked = blank_en && (idx != '0) && zero_from[idx];

    // Output select for the current slot; a blanked slot is fully dark.
    always_comb begin
        digit_out = '0;
        dp_out    = 1'b0;
        an_out    = '0;
        if (!blanked) begin
            digit_out = active_val[4*idx +: 4];
            dp_out    = active_dp[idx];
            an_out    = NUM_DIGITS'(1) << idx;
        end
    end
endmodule
